// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
// Bundle of the control sequencer's datapath-facing signals.
//   master : the sequencer (multicycle_ctrl). It reads enable, inst,
//            alu_zero and mem_ready, and drives the datapath strobes,
//            the status flags and instr_count.
//   slave  : the datapath / environment side. Directions are the
//            reverse of master.
interface multicycle_ctrl_if;
  logic       enable;
  logic [7:0] inst;
  logic       alu_zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_src;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       alu_src;
  logic [1:0] alu_op;
  logic       mem_to_reg;
  logic       busy;
  logic       halted;
  logic       fault;
  logic [7:0] instr_count;

  modport master (
    input  enable, inst, alu_zero, mem_ready,
    output pc_write, pc_src, ir_write, reg_write, mem_read, mem_write,
           alu_src, alu_op, mem_to_reg, busy, halted, fault, instr_count
  );

  modport slave (
    output enable, inst, alu_zero, mem_ready,
    input  pc_write, pc_src, ir_write, reg_write, mem_read, mem_write,
           alu_src, alu_op, mem_to_reg, busy, halted, fault, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Multi-cycle control sequencer for the 8-bit datapath. Each instruction
// is stepped through FETCH, DECODE, EXEC, (MEM), (WB). The sequencer drives
// the PC, IR, register-file, ALU and data-memory strobes, and it counts
// retired instructions. A retirement is any cycle with pc_write high.
// Ports:
//   clk   : single clock, rising edge.
//   reset : synchronous, active-high. Forces IDLE, clears the count and
//           the MEM wait counter.
//   bus   : multicycle_ctrl_if.master. Carries enable, inst, alu_zero and
//           mem_ready in, and the strobes, status and instr_count out.
// Parameter:
//   MEM_TIMEOUT : maximum number of consecutive MEM cycles with mem_ready
//                 low before the sequencer enters FAULT. 0 disables the
//                 timeout. Valid range is 0..15.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [2:0] OP_ADDI  = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] OP_BRZ   = 3'b111;
  localparam logic [4:0] TIMEOUT_LIM = 5'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [2:0] opcode_q, opcode_d;
  logic [3:0] wait_q, wait_d;
  logic [7:0] count_q, count_d;

  logic       pc_write, pc_src, ir_write, reg_write;
  logic       mem_read, mem_write, alu_src, mem_to_reg;
  logic [1:0] alu_op;
  logic [1:0] alu_op_dec;
  logic       alu_src_dec;
  logic [4:0] wait_inc;
  state_t     boundary;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opcode_q <= 3'b000;
      wait_q   <= 4'd0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      wait_q   <= wait_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    wait_d     = wait_q;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    mem_to_reg = 1'b0;

    // ALU controls are a pure function of the latched opcode. They are
    // driven in EXEC and held unchanged through MEM and WB.
    alu_op_dec  = opcode_q[2] ? 2'b00 : opcode_q[1:0];
    alu_src_dec = (opcode_q == OP_ADDI) || (opcode_q == OP_LOAD) ||
                  (opcode_q == OP_STORE);
    wait_inc    = {1'b0, wait_q} + 5'd1;
    // enable is only looked at once an instruction has fully retired.
    boundary    = bus.enable ? S_FETCH : S_IDLE;

    unique case (state_q)
      S_IDLE: begin
        if (bus.enable) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        opcode_d = bus.inst[7:5];
        // The all-ones encoding is HALT. It takes priority over BRZ.
        state_d  = (bus.inst == 8'hFF) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alu_op  = alu_op_dec;
        alu_src = alu_src_dec;
        if (opcode_q == OP_BRZ) begin
          pc_write = 1'b1;
          pc_src   = bus.alu_zero;
          state_d  = boundary;
        end else if (opcode_q == OP_LOAD || opcode_q == OP_STORE) begin
          wait_d  = 4'd0;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_op    = alu_op_dec;
        alu_src   = alu_src_dec;
        mem_read  = (opcode_q == OP_LOAD);
        mem_write = (opcode_q == OP_STORE);
        if (bus.mem_ready) begin
          // A ready on the cycle the limit would be reached still wins.
          if (opcode_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            pc_write = 1'b1;
            state_d  = boundary;
          end
        end else if (TIMEOUT_LIM != 5'd0 && wait_inc == TIMEOUT_LIM) begin
          state_d = S_FAULT;
        end else if (wait_q != 4'hF) begin
          // Saturate so a disabled timeout never wraps the counter.
          wait_d = wait_inc[3:0];
        end
      end
      S_WB: begin
        alu_op     = alu_op_dec;
        alu_src    = alu_src_dec;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = (opcode_q == OP_LOAD);
        state_d    = boundary;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    count_d = count_q + {7'd0, pc_write};
  end

  assign bus.pc_write    = pc_write;
  assign bus.pc_src      = pc_src;
  assign bus.ir_write    = ir_write;
  assign bus.reg_write   = reg_write;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.alu_src     = alu_src;
  assign bus.alu_op      = alu_op;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT) &&
                           (state_q != S_FAULT);
  assign bus.halted      = (state_q == S_HALT);
  assign bus.fault       = (state_q == S_FAULT);
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Scoreboard bench for multicycle_ctrl. The driver issues one instruction
// at a time and pushes the retirement it expects, taken from a behavioural
// table of the instruction set. A separate monitor pops one entry on each
// pc_write cycle and compares against it. A memory responder answers MEM
// accesses after a chosen number of wait cycles. Outside MEM, the responder
// drives random noise on mem_ready.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] inst;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    int         latency;
    int         mem_cycles;
    logic [7:0] count;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_count;
  int         wait_target;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Expected retirement of one instruction, derived from the instruction
  // set table. w is the number of MEM wait cycles, z is the ALU zero flag,
  // and cnt is the retirement count expected after this instruction.
  function automatic exp_t model(input logic [7:0] ins, input int w,
                                 input logic z, input logic [7:0] cnt);
    exp_t e;
    logic [2:0] op;
    op           = ins[7:5];
    e.inst       = ins;
    e.alu_op     = 2'b00;
    e.alu_src    = 1'b0;
    e.pc_src     = 1'b0;
    e.reg_write  = 1'b0;
    e.mem_to_reg = 1'b0;
    e.latency    = 0;
    e.mem_cycles = 0;
    e.count      = cnt;
    case (op)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        e.alu_op = op[1:0]; e.reg_write = 1'b1; e.latency = 4;
      end
      3'd4: begin e.alu_src = 1'b1; e.reg_write = 1'b1; e.latency = 4; end
      3'd5: begin
        e.alu_src = 1'b1; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
        e.latency = 5 + w; e.mem_cycles = w + 1;
      end
      3'd6: begin
        e.alu_src = 1'b1; e.latency = 4 + w; e.mem_cycles = w + 1;
      end
      default: begin e.pc_src = z; e.latency = 3; end
    endcase
    return e;
  endfunction

  // Memory responder: raises mem_ready on the (wait_target+1)-th MEM cycle.
  initial begin
    int mcnt;
    mcnt = 0;
    bus.mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_read || bus.mem_write) begin
        bus.mem_ready = (mcnt == wait_target);
        mcnt++;
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
        mcnt = 0;
      end
    end
  end

  // Monitor: pops and compares one expectation per retirement.
  initial begin
    int   lat, mcyc;
    bit   in_instr, cnt_pend;
    logic [7:0] cnt_exp;
    exp_t e;
    lat = 0; mcyc = 0; in_instr = 0; cnt_pend = 0; cnt_exp = 8'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_instr = 0; lat = 0; mcyc = 0; cnt_pend = 0;
      end else begin
        if (cnt_pend) begin
          check("instr_count", bus.instr_count, cnt_exp);
          cnt_pend = 0;
        end
        if (bus.ir_write) begin
          in_instr = 1; lat = 1; mcyc = 0;
        end else if (in_instr) begin
          lat++;
        end
        if (bus.mem_read || bus.mem_write) mcyc++;
        if (bus.mem_write) check("reg_write_vs_mem_write", bus.reg_write, 0);
        if (bus.pc_write) begin
          if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_retire: pc_write=1, required no retirement");
          end else begin
            e = sb_q.pop_front();
            check("ir_write_vs_pc_write", bus.ir_write, 0);
            check("alu_op", bus.alu_op, e.alu_op);
            check("alu_src", bus.alu_src, e.alu_src);
            check("pc_src", bus.pc_src, e.pc_src);
            check("reg_write", bus.reg_write, e.reg_write);
            check("mem_to_reg", bus.mem_to_reg, e.mem_to_reg);
            check("latency", lat, e.latency);
            check("mem_cycles", mcyc, e.mem_cycles);
            $display("retire inst=%02h lat=%0d mem_cycles=%0d count=%0d",
                     e.inst, lat, mcyc, e.count);
            cnt_exp = e.count; cnt_pend = 1;
          end
          in_instr = 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.enable = 1'b0;
    @(negedge clk);
    check("reset_outputs", {bus.pc_write, bus.pc_src, bus.ir_write,
          bus.reg_write, bus.mem_read, bus.mem_write, bus.alu_src,
          bus.alu_op, bus.mem_to_reg, bus.busy, bus.halted, bus.fault}, 0);
    check("reset_count", bus.instr_count, 0);
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    exp_count = 8'd0;
  endtask

  // Issue one instruction and wait (bounded) for its retirement.
  task automatic run_instr(input logic [7:0] ins, input int w,
                           input logic z, input bit drop_en);
    int k, cyc;
    bit done, fetched;
    bus.inst = ins; bus.alu_zero = z; wait_target = w; bus.enable = 1'b1;
    exp_count = exp_count + 8'd1;
    sb_q.push_back(model(ins, w, z, exp_count));
    done = 0; fetched = 0; k = 0; cyc = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
      if (bus.ir_write) begin fetched = 1; cyc = 1; end
      else if (fetched) cyc++;
      if (drop_en && cyc == 3) bus.enable = 1'b0;
      if (bus.pc_write) done = 1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL retire_timeout: inst=%02h got no retirement, required one within 200 cycles", ins);
    end
    #1;
  endtask

  task automatic run_random();
    logic [7:0] ins;
    ins = 8'($urandom);
    if (ins == 8'hFF) ins = 8'hFE;
    run_instr(ins, $urandom_range(0, 5), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0));
  endtask

  initial begin
    int k, mw;
    reset = 1'b1; bus.enable = 1'b0; bus.inst = 8'h00; bus.alu_zero = 1'b0;
    wait_target = 0; exp_count = 8'd0;
    do_reset();

    // ADD stream, LOAD with 3 wait cycles, BRZ taken and not taken.
    repeat (3) run_instr(8'h00, 0, 1'b0, 1'b0);
    run_instr(8'hA0, 3, 1'b0, 1'b0);
    run_instr(8'hE2, 0, 1'b1, 1'b0);
    run_instr(8'hE2, 0, 1'b0, 1'b0);

    // SUB with enable dropped in EXEC still completes, then goes idle.
    run_instr(8'h20, 0, 1'b0, 1'b1);
    @(negedge clk);
    check("idle_after_drop_busy", bus.busy, 0);
    check("idle_after_drop_ir_write", bus.ir_write, 0);

    // Random traffic, then march the count to 255 and wrap it with one more.
    repeat (150) run_random();
    while (exp_count != 8'd255) run_random();
    run_instr(8'h00, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("wrap_count", bus.instr_count, 0);
    repeat (40) run_random();

    // Reset in the middle of a LOAD that is still waiting in MEM.
    do_reset();
    wait_target = 1000; bus.inst = 8'hA0; bus.enable = 1'b1;
    k = 0;
    while (!bus.mem_read && k < 20) begin @(negedge clk); k++; end
    check("mid_reset_mem_reached", bus.mem_read, 1);
    repeat (2) @(negedge clk);
    do_reset();

    // HALT after two ADDs: sticky, ignores enable, not counted.
    run_instr(8'h00, 0, 1'b0, 1'b0);
    run_instr(8'h00, 0, 1'b0, 1'b0);
    bus.inst = 8'hFF;
    k = 0;
    while (!bus.halted && k < 10) begin @(negedge clk); k++; end
    check("halt_reached", bus.halted, 1);
    check("halt_count", bus.instr_count, 2);
    check("halt_busy", bus.busy, 0);
    for (int i = 0; i < 8; i++) begin
      bus.enable = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("halt_sticky", {bus.halted, bus.pc_write, bus.ir_write}, 3'b100);
    end
    do_reset();

    // STORE with mem_ready stuck low: 15 write cycles, then FAULT.
    wait_target = 1000; bus.inst = 8'hC0; bus.enable = 1'b1;
    mw = 0; k = 0;
    while (!bus.fault && k < 60) begin
      @(negedge clk);
      if (bus.mem_write) mw++;
      k++;
    end
    check("fault_reached", bus.fault, 1);
    check("fault_mem_write_cycles", mw, 15);
    check("fault_strobes", {bus.pc_write, bus.ir_write, bus.reg_write,
          bus.mem_read, bus.mem_write, bus.busy}, 0);
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    check("fault_sticky", bus.fault, 1);
    do_reset();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
